instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 20, instruction word width.
REQ-002 SHALL have parameter ADDR_BITS, default 5, instruction-ROM address width (32 words).
REQ-003 SHALL have parameters HOLD_ALU=3, HOLD_STORE=3, HOLD_LOAD=4: issue cycles per opcode class, each legal in 1..15.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle pulse to begin execution from IDLE.
REQ-007 SHALL have port rom_en, output, 1, instruction-ROM read enable.
REQ-008 SHALL have port rom_addr, output, ADDR_BITS, ROM read address.
REQ-009 SHALL have port rom_data, input, INSTR_WIDTH, ROM read data, valid one cycle after rom_en.
REQ-010 SHALL have port instr_out, output, INSTR_WIDTH, instruction driven to simple_cpu.
REQ-011 SHALL have port instr_valid, output, 1, high while instr_out carries an issued instruction.
REQ-012 SHALL have port pc, output, ADDR_BITS, address of current/next instruction.
REQ-013 SHALL have ports busy, output, 1 (not IDLE/HALTED), and halted, output, 1 (in HALTED).

Function
REQ-014 SHALL implement states IDLE, FETCH, LATCH, ISSUE, HALTED.
REQ-015 IDLE: start=1 SHALL go to FETCH next cycle; otherwise stay.
REQ-016 FETCH: SHALL assert rom_en=1, rom_addr=pc for exactly one cycle, then go to LATCH.
REQ-017 LATCH: SHALL register rom_data; opcode bits [19:18]=00 SHALL go to HALTED, else to ISSUE with hold counter loaded with hold-1.
REQ-018 Hold selection SHALL be: opcode 01 (ALU ADD/SUB) HOLD_ALU, 11 (STORE_R) HOLD_STORE, 10 (LOAD_R) HOLD_LOAD.
REQ-019 ISSUE: instr_out SHALL equal the latched word and instr_valid=1 for exactly the selected hold count of consecutive cycles.
REQ-020 Last ISSUE cycle (counter=0): pc SHALL increment by 1 and state SHALL go to FETCH.
REQ-021 pc SHALL wrap from 2^ADDR_BITS-1 to 0 without halting.
REQ-022 Outside ISSUE, instr_out SHALL be all-zero and instr_valid=0 (zero word is benign to simple_cpu).
REQ-023 Per instruction, latency from FETCH entry to first ISSUE cycle SHALL be 2 cycles; total cycles per instruction SHALL be hold+2.
REQ-024 start SHALL be ignored in every state except IDLE.
REQ-025 HALTED SHALL be left only by reset; pc SHALL hold the address of the halting word.
REQ-026 rom_en SHALL be 0 in every state except FETCH.

Reset
REQ-027 rst=0 at a rising edge SHALL, from any state including mid-ISSUE, force IDLE, pc=0, counter=0, latched word=0.
REQ-028 During and after reset: rom_en=0, rom_addr=0, instr_out=0, instr_valid=0, busy=0, halted=0.

Configuration
REQ-029 With SEQ_STEP_EN defined, SHALL add inputs step_mode (1b) and step (1b pulse) and state PAUSE: after last ISSUE cycle with step_mode=1, go to PAUSE (busy=1, instr_out=0) and on step=1 go to FETCH.
REQ-030 Without SEQ_STEP_EN, ports step_mode/step and state PAUSE SHALL not exist; behaviour per REQ-020.

Structure
REQ-031 Package cpu_pkg SHALL hold opcode constants (OP_HALT=00, OP_ALU=01, OP_LOAD=10, OP_STORE=11), opcode field position [19:18] and the state enum typedef.
REQ-032 Hold counter SHALL be sub-module hold_counter (load value, decrement, zero flag); rest inline.

Verification
REQ-033 ROM[0]=20'b01000111000000000000, ROM[1]=0, reset then start -> rom_en at cycle 1, instr_out=ROM[0] valid cycles 3-5, pc=1 at cycle 6, FETCH cycle 6, HALTED cycle 8, halted=1.
REQ-034 ROM[0..2]=ADD, STORE_R 20'b11011000000011110000, LOAD_R 20'b10111000000011110000, ROM[3]=0 -> valid widths 3,3,4 cycles, each preceded by 2 zero cycles, halt at pc=3.
REQ-035 ROM filled with ALU words, run 32 instructions -> pc wraps 31->0, busy stays 1, halted=0.
REQ-036 rst=0 on second ISSUE cycle -> next cycle instr_out=0, instr_valid=0, pc=0, IDLE; start again re-executes ROM[0].
REQ-037 start pulsed during ISSUE and HALTED -> no state/pc change.
REQ-038 SEQ_STEP_EN, step_mode=1 -> PAUSE after each instruction, no rom_en until step; step=1 -> FETCH next cycle at pc+1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode encoding, opcode field position and sequencer state type.
// The PAUSE state exists only when SEQ_STEP_EN is defined.
package cpu_pkg;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam int OP_MSB = 19;
    localparam int OP_LSB = 18;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_HALTED
`ifdef SEQ_STEP_EN
        , S_PAUSE
`endif
    } state_e;

    function automatic logic [CNT_W-1:0] hold_for(logic [1:0] op, int ha, int hs, int hl);
        return op == OP_ALU ? CNT_W'(ha) : op == OP_STORE ? CNT_W'(hs) :
               op == OP_LOAD ? CNT_W'(hl) : '0;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: ROM fetch and instruction issue signals of the sequencer.
// step_mode/step exist only when SEQ_STEP_EN is defined.
interface instr_sequencer_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5
);

    logic                   start;
    logic                   rom_en;
    logic [ADDR_BITS-1:0]   rom_addr;
    logic [INSTR_WIDTH-1:0] rom_data;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic                   instr_valid;
    logic [ADDR_BITS-1:0]   pc;
    logic                   busy;
    logic                   halted;
`ifdef SEQ_STEP_EN
    logic                   step_mode;
    logic                   step;
`endif

    modport master (
        input  start, rom_data,
`ifdef SEQ_STEP_EN
        input  step_mode, step,
`endif
        output rom_en, rom_addr, instr_out, instr_valid, pc, busy, halted
    );

    modport slave (
        output start, rom_data,
`ifdef SEQ_STEP_EN
        output step_mode, step,
`endif
        input  rom_en, rom_addr, instr_out, instr_valid, pc, busy, halted
    );

endinterface

// File: rtl/hold_counter.sv
// hold_counter: loadable down-counter that saturates at zero and flags it.
module hold_counter
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = load ? load_val : (dec && count_q != '0) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign zero = count_q == '0;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches ROM words and issues each for an opcode-dependent hold count.
// Defining SEQ_STEP_EN adds a single-step PAUSE state driven by step_mode/step.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5,
    parameter int HOLD_ALU    = 3,
    parameter int HOLD_STORE  = 3,
    parameter int HOLD_LOAD   = 4
) (
    input logic              clk,
    input logic              rst,
    instr_sequencer_if.master bus
);

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]       hold_val;
    logic [1:0]             op;
    logic                   cnt_zero;

    assign op       = bus.rom_data[OP_MSB:OP_LSB];
    assign hold_val = hold_for(op, HOLD_ALU, HOLD_STORE, HOLD_LOAD) - 1'b1;

    hold_counter u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == S_LATCH),
        .dec      (state_q == S_ISSUE),
        .load_val (hold_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = bus.start ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = S_LATCH;
            S_LATCH:  state_d = op == OP_HALT ? S_HALTED : S_ISSUE;
`ifdef SEQ_STEP_EN
            S_ISSUE:  state_d = cnt_zero ? (bus.step_mode ? S_PAUSE : S_FETCH) : S_ISSUE;
            S_PAUSE:  state_d = bus.step ? S_FETCH : S_PAUSE;
`else
            S_ISSUE:  state_d = cnt_zero ? S_FETCH : S_ISSUE;
`endif
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // pc wraps naturally at 2^ADDR_BITS; the halting word keeps its own address
    always_comb begin
        pc_d    = (state_q == S_ISSUE && cnt_zero) ? pc_q + 1'b1 : pc_q;
        instr_d = state_q == S_LATCH ? bus.rom_data : instr_q;
    end

    // outputs are forced quiet while reset is held, not only after the edge
    always_comb begin
        bus.rom_en      = rst && state_q == S_FETCH;
        bus.rom_addr    = bus.rom_en ? pc_q : '0;
        bus.instr_valid = rst && state_q == S_ISSUE;
        bus.instr_out   = bus.instr_valid ? instr_q : '0;
        bus.pc          = pc_q;
        bus.busy        = rst && state_q != S_IDLE && state_q != S_HALTED;
        bus.halted      = rst && state_q == S_HALTED;
    end

endmodule
